instruction_memory_pipelined: RTL and testbench
===============================================

Name: instruction_memory_pipelined

Overview:
Parametrised, byte-addressable, big-endian instruction memory with a registered, pipelined read path and a valid/ready request interface. It replaces the combinational instruction ROM on the fetch path of the MIPS core. It adds configurable depth, word width and read latency, alignment and range checking, and a byte-wide loader write port for program download.

Parameters:
ADDR_WIDTH, 32, width of req_addr and load_addr in bits.
DEPTH_BYTES, 1024, number of bytes in the memory array (power of two, ≥ WORD_BYTES).
WORD_BYTES, 4, bytes per returned instruction word (1, 2, 4 or 8).
READ_LATENCY, 1, cycles from request acceptance to resp_valid (1..4).

Ports:
clk  input  1  clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
req_valid  input  1  fetch request present.
req_ready  output  1  request can be accepted this cycle.
req_addr  input  ADDR_WIDTH  byte address of the fetch.
resp_valid  output  1  response word valid (one-cycle pulse per accepted request).
resp_instr  output  8*WORD_BYTES  fetched word, big-endian assembled.
resp_error  output  1  accepted request was misaligned or out of range; qualified by resp_valid.
load_en  input  1  loader byte write strobe.
load_addr  input  ADDR_WIDTH  loader byte address.
load_byte  input  8  loader byte data.
busy  output  1  at least one read is in flight in the pipeline.

Behaviour:
- Storage: byte array named memory, DEPTH_BYTES entries of 8 bits. It is not cleared by reset. Benches may preload it hierarchically.
- Reset (asynchronous): all pipeline valid bits clear. resp_valid=0, resp_instr=0, resp_error=0, busy=0. Memory contents are untouched. Asserting reset mid-read discards every in-flight request; no response is ever produced for it.
- req_ready = !load_en && !reset. A request is accepted on a rising edge with req_valid && req_ready. Reads never stall for backpressure: the consumer must always accept responses.
- Throughput: one request per cycle. Up to READ_LATENCY requests may be in flight.
- Latency: a request accepted at edge N produces resp_valid=1 for exactly the cycle following edge N+READ_LATENCY-1. READ_LATENCY=1 means the response appears in the cycle after acceptance. Responses return in acceptance order.
- Data sampling: the memory bytes are read at the acceptance edge. Later loader writes do not affect a request already in flight.
- Assembly: resp_instr = {memory[a], memory[a+1], ..., memory[a+WORD_BYTES-1]}, where a = req_addr. The lowest address is the most significant byte.
- Error: error = (req_addr mod WORD_BYTES != 0) OR (req_addr > DEPTH_BYTES-WORD_BYTES). On error, resp_instr=0 and resp_error=1, with the same latency. There are no out-of-bounds array accesses.
- resp_instr and resp_error hold their last value while resp_valid=0, except that after reset they read 0.
- Loader: on a rising edge with load_en=1 and load_addr < DEPTH_BYTES, memory[load_addr] <= load_byte. Out-of-range loads are ignored silently. Loads take priority: a request presented with load_en=1 is not accepted.
- Same-edge case: if load_en rises on the same edge that a request was accepted in the previous cycle, the in-flight request keeps its old data (see Data sampling).
- busy = OR of the pipeline valid bits, excluding the output stage once it is presented.

Test Plan:
1. Preload memory[0..11] = DE AD BE EF CA FE BA BE 12 34 56 78, READ_LATENCY=1. Issue back-to-back requests at 0, 4, 8 → resp_valid on 3 consecutive cycles with resp_instr DEADBEEF, CAFEBABE, 12345678, resp_error=0.
2. READ_LATENCY=3, the same three back-to-back requests → first resp_valid exactly 3 cycles after first acceptance, then 3 contiguous responses in order, busy=1 throughout.
3. Request at addr 2 (misaligned) and at addr DEPTH_BYTES (out of range) → each gives resp_valid=1, resp_error=1, resp_instr=00000000.
4. Loader writes 11 22 33 44 to addrs 16..19 while req_valid=1 at addr 16 → req_ready=0 during the loads. The first accepted read returns 11223344.
5. Accept a read at 0, then on the next edge load 0x99 to addr 0 → the in-flight response is still DEADBEEF. A subsequent read returns 99ADBEEF.
6. Assert reset with 2 requests in flight (READ_LATENCY=3) → no resp_valid ever appears for them. After release, outputs are 0 and the preloaded memory still reads DEADBEEF at addr 0.

Source files
------------

// File: rtl/instruction_memory_pipelined.sv
// Byte-addressable, big-endian instruction memory with a pipelined read path,
// valid/ready request handshake, alignment/range checking and a byte loader.
module instruction_memory_pipelined #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DEPTH_BYTES  = 1024,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  output logic                      resp_valid,
  output logic [8*WORD_BYTES-1:0]   resp_instr,
  output logic                      resp_error,
  input  logic                      load_en,
  input  logic [ADDR_WIDTH-1:0]     load_addr,
  input  logic [7:0]                load_byte,
  output logic                      busy
);

  localparam int unsigned IDX_W  = $clog2(DEPTH_BYTES);
  localparam int unsigned WORD_W = 8 * WORD_BYTES;

  logic [7:0]              memory [DEPTH_BYTES];

  logic                    accept;
  logic                    rd_err;
  logic [WORD_W-1:0]       rd_word;
  logic [IDX_W-1:0]        rd_base;
  logic                    load_in_range;

  // Stage 0 captures the read at acceptance; the last stage is the output.
  logic [READ_LATENCY-1:0] pv;
  logic [WORD_W-1:0]       pdata [READ_LATENCY];
  logic                    perr  [READ_LATENCY];

  assign req_ready     = !load_en && !reset;
  assign accept        = req_valid && req_ready;
  assign rd_base       = req_addr[IDX_W-1:0];
  assign load_in_range = 64'(load_addr) < 64'(DEPTH_BYTES);

  // Classify the request and assemble the big-endian word (zero on error).
  always_comb begin
    rd_err  = ((req_addr & ADDR_WIDTH'(WORD_BYTES - 1)) != '0) ||
              (64'(req_addr) > 64'(DEPTH_BYTES - WORD_BYTES));
    rd_word = '0;
    if (!rd_err) begin
      for (int unsigned k = 0; k < WORD_BYTES; k++) begin
        rd_word[8*(WORD_BYTES-1-k) +: 8] = memory[rd_base + IDX_W'(k)];
      end
    end
  end

  // Loader byte writes; out-of-range addresses are dropped. Not reset.
  always_ff @(posedge clk) begin
    if (load_en && load_in_range) begin
      memory[load_addr[IDX_W-1:0]] <= load_byte;
    end
  end

  // Read pipeline: valid bits always shift, data only moves behind a valid
  // bit so the output stage holds its last response between pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pv <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        pdata[i] <= '0;
        perr[i]  <= 1'b0;
      end
    end else begin
      pv[0] <= accept;
      if (accept) begin
        pdata[0] <= rd_word;
        perr[0]  <= rd_err;
      end
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        if (pv[i-1]) begin
          pdata[i] <= pdata[i-1];
          perr[i]  <= perr[i-1];
        end
      end
    end
  end

  assign resp_valid = pv[READ_LATENCY-1];
  assign resp_instr = pdata[READ_LATENCY-1];
  assign resp_error = perr[READ_LATENCY-1];

  // In-flight reads exclude the output stage, which is already presented.
  generate
    if (READ_LATENCY == 1) begin : g_busy_l1
      assign busy = 1'b0;
    end else begin : g_busy_ln
      assign busy = |pv[READ_LATENCY-2:0];
    end
  endgenerate

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Directed bench: two instances (read latency 1 and 3) share one stimulus
// stream and are checked cycle by cycle against a hand-computed table.
module tb_instruction_memory_pipelined;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        load_en;
  logic [31:0] load_addr;
  logic [7:0]  load_byte;

  logic        rdy1, v1, e1, b1;
  logic [31:0] d1;
  logic        rdy3, v3, e3, b3;
  logic [31:0] d3;

  int checks = 0;
  int errors = 0;
  int vidx   = -1;

  instruction_memory_pipelined #(
    .ADDR_WIDTH(32), .DEPTH_BYTES(1024), .WORD_BYTES(4), .READ_LATENCY(1)
  ) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy1),
    .req_addr(req_addr), .resp_valid(v1), .resp_instr(d1), .resp_error(e1),
    .load_en(load_en), .load_addr(load_addr), .load_byte(load_byte), .busy(b1)
  );

  instruction_memory_pipelined #(
    .ADDR_WIDTH(32), .DEPTH_BYTES(1024), .WORD_BYTES(4), .READ_LATENCY(3)
  ) dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy3),
    .req_addr(req_addr), .resp_valid(v3), .resp_instr(d3), .resp_error(e3),
    .load_en(load_en), .load_addr(load_addr), .load_byte(load_byte), .busy(b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rv;
    logic [31:0] ra;
    logic        le;
    logic [31:0] la;
    logic [7:0]  lb;
    logic        rdy;
    logic        v1;
    logic [31:0] d1;
    logic        e1;
    logic        v3;
    logic [31:0] d3;
    logic        e3;
    logic        b3;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, vidx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rv, input logic [31:0] ra,
                              input logic le, input logic [31:0] la, input logic [7:0] lb,
                              input logic rdy,
                              input logic xv1, input logic [31:0] xd1, input logic xe1,
                              input logic xv3, input logic [31:0] xd3, input logic xe3,
                              input logic xb3);
    vec_t v;
    v.rv = rv; v.ra = ra; v.le = le; v.la = la; v.lb = lb; v.rdy = rdy;
    v.v1 = xv1; v.d1 = xd1; v.e1 = xe1;
    v.v3 = xv3; v.d3 = xd3; v.e3 = xe3; v.b3 = xb3;
    return v;
  endfunction

  task automatic idle_inputs();
    req_valid = 1'b0; req_addr = '0;
    load_en = 1'b0; load_addr = '0; load_byte = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] pre [12];
    pre = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBE,
            8'h12, 8'h34, 8'h56, 8'h78};
    for (int i = 0; i < 1024; i++) begin
      dut1.memory[i] = 8'h00;
      dut3.memory[i] = 8'h00;
    end
    for (int i = 0; i < 12; i++) begin
      dut1.memory[i] = pre[i];
      dut3.memory[i] = pre[i];
    end

    reset = 1'b1;
    idle_inputs();
    #12;
    chk("reset_valid1", 32'(v1), 32'd0);
    chk("reset_instr3", d3, 32'd0);
    chk("reset_busy3", 32'(b3), 32'd0);
    chk("reset_ready", 32'(rdy1), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset with two reads in flight in the latency-3 instance.
    @(negedge clk); req_valid = 1'b1; req_addr = 32'd0;
    @(negedge clk); req_addr = 32'd4;
    @(negedge clk); idle_inputs();
    chk("inflight_busy3", 32'(b3), 32'd1);
    chk("inflight_v1_data", d1, 32'hCAFEBABE);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_v1", 32'(v1), 32'd0);
    chk("async_rst_d1", d1, 32'd0);
    chk("async_rst_v3", 32'(v3), 32'd0);
    chk("async_rst_b3", 32'(b3), 32'd0);
    chk("async_rst_e3", 32'(e3), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("post_rst_no_v3", 32'(v3), 32'd0);
      chk("post_rst_no_v1", 32'(v1), 32'd0);
    end
    @(negedge clk); req_valid = 1'b1; req_addr = 32'd0;
    @(negedge clk); idle_inputs();
    chk("post_rst_read1", d1, 32'hDEADBEEF);
    begin
      int waited = 0;
      while (v3 !== 1'b1 && waited < 10) begin
        @(posedge clk); #1;
        waited++;
      end
      chk("post_rst_read3_timely", 32'(waited), 32'd2);
      chk("post_rst_read3", d3, 32'hDEADBEEF);
    end

    do_reset();

    //           rv  ra     le la     lb     rdy v1 d1            e1 v3 d3            e3 b3
    vecs.push_back(mk(1, 0,     0, 0,    8'h00, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(1, 4,     0, 0,    8'h00, 1, 1, 32'hCAFEBABE, 0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(1, 8,     0, 0,    8'h00, 1, 1, 32'h12345678, 0, 1, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h12345678, 0, 1, 32'hCAFEBABE, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h12345678, 0, 1, 32'h12345678, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h12345678, 0, 0, 32'h12345678, 0, 0));
    vecs.push_back(mk(1, 2,     0, 0,    8'h00, 1, 1, 32'h0,        1, 0, 32'h12345678, 0, 1));
    vecs.push_back(mk(1, 1024,  0, 0,    8'h00, 1, 1, 32'h0,        1, 0, 32'h12345678, 0, 1));
    vecs.push_back(mk(1, 1020,  0, 0,    8'h00, 1, 1, 32'h0,        0, 1, 32'h0,        1, 1));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h0,        0, 1, 32'h0,        1, 1));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h0,        0, 1, 32'h0,        0, 0));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 16,    1, 16,   8'h11, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 16,    1, 17,   8'h22, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 16,    1, 18,   8'h33, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 16,    1, 19,   8'h44, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 16,    0, 0,    8'h00, 1, 1, 32'h11223344, 0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h11223344, 0, 0, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h11223344, 0, 1, 32'h11223344, 0, 0));
    vecs.push_back(mk(1, 0,     0, 0,    8'h00, 1, 1, 32'hDEADBEEF, 0, 0, 32'h11223344, 0, 1));
    vecs.push_back(mk(0, 0,     1, 0,    8'h99, 0, 0, 32'hDEADBEEF, 0, 0, 32'h11223344, 0, 1));
    vecs.push_back(mk(1, 0,     0, 0,    8'h00, 1, 1, 32'h99ADBEEF, 0, 1, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(0, 0,     1, 1024, 8'h55, 0, 0, 32'h99ADBEEF, 0, 0, 32'hDEADBEEF, 0, 1));
    vecs.push_back(mk(1, 0,     0, 0,    8'h00, 1, 1, 32'h99ADBEEF, 0, 1, 32'h99ADBEEF, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h99ADBEEF, 0, 0, 32'h99ADBEEF, 0, 1));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h99ADBEEF, 0, 1, 32'h99ADBEEF, 0, 0));
    vecs.push_back(mk(0, 0,     0, 0,    8'h00, 1, 0, 32'h99ADBEEF, 0, 0, 32'h99ADBEEF, 0, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      vidx = k;
      @(negedge clk);
      req_valid = vecs[k].rv;
      req_addr  = vecs[k].ra;
      load_en   = vecs[k].le;
      load_addr = vecs[k].la;
      load_byte = vecs[k].lb;
      #1;
      chk("req_ready1", 32'(rdy1), 32'(vecs[k].rdy));
      chk("req_ready3", 32'(rdy3), 32'(vecs[k].rdy));
      @(posedge clk); #1;
      chk("resp_valid1", 32'(v1), 32'(vecs[k].v1));
      chk("resp_instr1", d1, vecs[k].d1);
      chk("resp_error1", 32'(e1), 32'(vecs[k].e1));
      chk("busy1", 32'(b1), 32'd0);
      chk("resp_valid3", 32'(v3), 32'(vecs[k].v3));
      chk("resp_instr3", d3, vecs[k].d3);
      chk("resp_error3", 32'(e3), 32'(vecs[k].e3));
      chk("busy3", 32'(b3), 32'(vecs[k].b3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
